fp_add_sequencer: RTL and testbench

- Multi-cycle sequential single-precision floating-point adder/subtractor controller.
- Accepts one operand pair through a valid/ready handshake and sequences unpack/swap, alignment, two's-complement add, and iterative normalisation through an FSM.
- Holds the packed result until the consumer takes it.
- Sits between the operand-issue logic and the result writeback path. Trades latency for area against the combinational adder.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_align_shift.sv | 20 ++
 rtl/fp_add_sequencer.sv | 155 +++++++++++++++
 tb/tb_fp_add_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state encoding and IEEE-754 field helpers
// used by the sequential adder and the combinational adder.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic f_sign(input logic [W-1:0] x);
        return x[W-1];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
        return x[W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] f_man(input logic [W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Mantissa alignment: one-cycle barrel right shift; amounts of DW or more give zero.
// Pure combinational, no flow control; shifted-out bits are truncated.
module fp_align_shift #(
    parameter int DW   = 24,
    parameter int SH_W = 8
) (
    input  logic [DW-1:0]   din_i,
    input  logic [SH_W-1:0] shamt_i,
    output logic [DW-1:0]   dout_o
);

    always_comb begin
        if (shamt_i >= SH_W'(DW)) begin
            dout_o = '0;
        end else begin
            dout_o = din_i >> shamt_i;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP32 add/sub: unpack/swap, align, add, iterative normalise; 4+k cycles (special: 1).
// One operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_add_sequencer #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         busy
);

    import fp_pkg::*;

    localparam int MW = MAN_W + 1;
    localparam int SW = MW + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q, op_b_q, res_q;
    logic             sign_a_q, sign_b_q, sign_r_q;
    logic [EXP_W:0]   exp_q;
    logic [EXP_W-1:0] diff_q;
    logic [MW-1:0]    man_a_q, man_b_q, man_b_sh;
    logic [SW-1:0]    sum_q;
    logic [4:0]       cnt_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
    logic             special, a_big, norm_exit;
    logic [EXP_W:0]   exp_inc, exp_dec;

    // Zero exponent flushes the operand (denormals included) to a zero mantissa.
    always_comb begin
        ea        = op_a_q[W-2 -: EXP_W];
        eb        = op_b_q[W-2 -: EXP_W];
        ma        = (ea == '0) ? '0 : {1'b1, op_a_q[MAN_W-1:0]};
        mb        = (eb == '0) ? '0 : {1'b1, op_b_q[MAN_W-1:0]};
        special   = (ea == EXP_ONES) || (eb == EXP_ONES);
        a_big     = (ea > eb) || ((ea == eb) && (ma >= mb));
        exp_inc   = exp_q + 1'b1;
        exp_dec   = exp_q - 1'b1;
        norm_exit = (sum_q == '0) || sum_q[SW-1] || sum_q[SW-2] ||
                    (exp_dec == '0) || (cnt_q == 5'(MW));
    end

    fp_align_shift #(.DW(MW), .SH_W(EXP_W)) u_align (
        .din_i   (man_b_q),
        .shamt_i (diff_q),
        .dout_o  (man_b_sh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = UNPACK;
            UNPACK:  state_d = special ? DONE : ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    if (norm_exit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sign_r_q <= 1'b0;
            exp_q    <= '0;
            diff_q   <= '0;
            man_a_q  <= '0;
            man_b_q  <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_a_q <= op_a;
                    op_b_q <= {op_b[W-1] ^ sub, op_b[W-2:0]};
                    cnt_q  <= '0;
                end
                UNPACK: if (special) begin
                    res_q <= QNAN;
                end else if (a_big) begin
                    sign_a_q <= op_a_q[W-1];
                    sign_b_q <= op_b_q[W-1];
                    man_a_q  <= ma;
                    man_b_q  <= mb;
                    exp_q    <= {1'b0, ea};
                    diff_q   <= ea - eb;
                end else begin
                    sign_a_q <= op_b_q[W-1];
                    sign_b_q <= op_a_q[W-1];
                    man_a_q  <= mb;
                    man_b_q  <= ma;
                    exp_q    <= {1'b0, eb};
                    diff_q   <= eb - ea;
                end
                ALIGN: man_b_q <= man_b_sh;
                ADD: begin
                    if (sign_a_q == sign_b_q) begin
                        sum_q <= {1'b0, man_a_q} + {1'b0, man_b_q};
                    end else begin
                        sum_q <= {1'b0, man_a_q} + (~{1'b0, man_b_q} + SW'(1));
                    end
                    // Exact cancellation always yields +0 regardless of operand signs.
                    sign_r_q <= (sign_a_q != sign_b_q && man_a_q == man_b_q) ? 1'b0 : sign_a_q;
                end
                NORM: begin
                    if (sum_q == '0) begin
                        res_q <= {sign_r_q, {(W-1){1'b0}}};
                    end else if (sum_q[SW-1]) begin
                        if (exp_inc >= {1'b0, EXP_ONES}) res_q <= {sign_r_q, EXP_ONES, {MAN_W{1'b0}}};
                        else res_q <= {sign_r_q, exp_inc[EXP_W-1:0], sum_q[MAN_W:1]};
                    end else if (sum_q[SW-2]) begin
                        res_q <= {sign_r_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
                    end else if ((exp_dec == '0) || (cnt_q == 5'(MW))) begin
                        res_q <= {sign_r_q, {(W-1){1'b0}}};
                    end else begin
                        sum_q <= sum_q << 1;
                        exp_q <= exp_dec;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: hand-computed FP32 sums, latencies,
// DONE backpressure and mid-operation reset.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, busy;
    logic [31:0] op_a, op_b, result;
    int          n_cmp = 0;
    int          n_err = 0;

    fp_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issues one operation; latency counts clk edges after the accepting edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h3F80_0000;
            @(posedge clk);
            @(negedge clk);
            check({tag, " held result"}, result, held);
            check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " no stray op"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", result, 32'h0000_0000);

        run_op("1+1", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4, 0);
        run_op("1-1", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4, 0);
        run_op("1.5+-1.25", 32'h3FC0_0000, 32'hBFA0_0000, 1'b0, 32'h3E80_0000, 6, 0);
        run_op("3-1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4, 0);
        run_op("1-3", 32'h3F80_0000, 32'h4040_0000, 1'b1, 32'hC000_0000, 4, 0);
        run_op("max+max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4, 3);
        // Special operands leave from UNPACK: accepting edge plus one more edge.
        run_op("inf+1", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1, 0);

        @(negedge clk);
        op_a = 32'h3FC0_0000; op_b = 32'hBFA0_0000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midop busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst result", result, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst in_ready", 32'(in_ready), 32'd1);
        run_op("1+1 after rst", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
